// File: rtl/phtime_freq_est.sv
// Recovers a frequency word from two successive (phase, time-count) samples as
// floor(dphase/dt) using a bit-serial restoring divider, one quotient bit per cycle.
module phtime_freq_est #(
   parameter int WIDTH = 27
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] phase,
   input  logic [WIDTH-1:0] tcnt,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] freq,
   output logic             freq_valid,
   output logic             err_dt0,
   output logic             primed
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state_reg, state_next;

   logic [WIDTH-1:0] prev_phase_reg;
   logic [WIDTH-1:0] prev_tcnt_reg;
   logic             primed_reg;
   logic [WIDTH-1:0] dividend_reg;
   logic [WIDTH-1:0] divisor_reg;
   logic [WIDTH:0]   rem_reg;
   logic [WIDTH-1:0] quot_reg;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] freq_reg;
   logic             err_reg;

   logic             accept;
   logic [WIDTH-1:0] dphase;
   logic [WIDTH-1:0] dt;
   logic             dt_zero;
   logic [WIDTH:0]   rem_shift;
   logic             rem_ge;
   logic [WIDTH:0]   rem_next;
   logic [WIDTH-1:0] quot_next;

   // Modular deltas: subtraction in WIDTH bits absorbs a wrap of either counter.
   assign dphase  = phase - prev_phase_reg;
   assign dt      = tcnt - prev_tcnt_reg;
   assign dt_zero = (dt == '0);
   assign accept  = in_valid && (state_reg == IDLE);

   // One restoring-division step: bring down the next dividend bit, try to subtract.
   assign rem_shift = {rem_reg[WIDTH-1:0], dividend_reg[WIDTH-1]};
   assign rem_ge    = (rem_shift >= {1'b0, divisor_reg});
   assign rem_next  = rem_ge ? (rem_shift - {1'b0, divisor_reg}) : rem_shift;
   assign quot_next = {quot_reg[WIDTH-2:0], rem_ge};

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      in_ready   = 1'b0;
      freq_valid = 1'b0;
      err_dt0    = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = 1'b1;
            if (accept && primed_reg) begin
               state_next = dt_zero ? DONE : DIV;
            end
         end
         DIV: begin
            if (count_reg == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            freq_valid = 1'b1;
            err_dt0    = err_reg;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_phase_reg <= '0;
         prev_tcnt_reg  <= '0;
         primed_reg     <= 1'b0;
         dividend_reg   <= '0;
         divisor_reg    <= '0;
         rem_reg        <= '0;
         quot_reg       <= '0;
         count_reg      <= '0;
         freq_reg       <= '0;
         err_reg        <= 1'b0;
      end else begin
         if (accept) begin
            prev_phase_reg <= phase;
            prev_tcnt_reg  <= tcnt;
            primed_reg     <= 1'b1;
            if (primed_reg) begin
               dividend_reg <= dphase;
               divisor_reg  <= dt;
               rem_reg      <= '0;
               quot_reg     <= '0;
               count_reg    <= CW'(WIDTH - 1);
               err_reg      <= dt_zero;
            end
         end
         if (state_reg == DIV) begin
            dividend_reg <= {dividend_reg[WIDTH-2:0], 1'b0};
            rem_reg      <= rem_next;
            quot_reg     <= quot_next;
            count_reg    <= count_reg - 1'b1;
            // Last step: publish the quotient so it is visible during DONE.
            if (count_reg == '0) begin
               freq_reg <= quot_next;
            end
         end
      end
   end

   assign freq   = freq_reg;
   assign primed = primed_reg;

endmodule

// File: tb/tb_phtime_freq_est.sv
// Self-checking bench for phtime_freq_est: directed vector table, hand sequences
// and randomized traffic against a cycle-level behavioural model.
module tb_phtime_freq_est;

   localparam int W = 27;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] phase;
   logic [W-1:0] tcnt;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] freq;
   logic         freq_valid;
   logic         err_dt0;
   logic         primed;

   phtime_freq_est #(.WIDTH(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .phase      (phase),
      .tcnt       (tcnt),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .freq       (freq),
      .freq_valid (freq_valid),
      .err_dt0    (err_dt0),
      .primed     (primed)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Behavioural model state: what has been accepted and when results are due.
   int           c;
   int           ready_at;
   int           valid_at;
   logic         m_primed;
   logic [W-1:0] m_prev_p, m_prev_t, m_freq, pend_freq;
   logic         pend_err;
   logic [W-1:0] last_t;

   typedef struct {
      logic         rst;
      logic [W-1:0] ph;
      logic [W-1:0] tc;
      logic         out;
      logic [W-1:0] f;
      logic         e;
   } vec_t;

   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, c, act, exp);
      end
   endtask

   // Check the current cycle against the model, drive one cycle of inputs, advance.
   task automatic step(input logic r, input logic v, input logic [W-1:0] p, input logic [W-1:0] t);
      logic         exp_ready;
      logic         exp_valid;
      logic [W-1:0] dp, dtm;
      exp_ready = (c >= ready_at);
      exp_valid = (c == valid_at);
      if (exp_valid && !pend_err) m_freq = pend_freq;
      chk("in_ready", 32'(in_ready), 32'(exp_ready));
      chk("freq_valid", 32'(freq_valid), 32'(exp_valid));
      chk("freq", 32'(freq), 32'(m_freq));
      chk("primed", 32'(primed), 32'(m_primed));
      chk("err_dt0", 32'(err_dt0), 32'(exp_valid && pend_err));
      reset    = r;
      in_valid = v;
      phase    = p;
      tcnt     = t;
      if (!r && v && exp_ready) begin
         if (m_primed) begin
            dp  = p - m_prev_p;
            dtm = t - m_prev_t;
            if (dtm == 0) begin
               pend_err = 1'b1;
               valid_at = c + 1;
               ready_at = c + 2;
            end else begin
               pend_err  = 1'b0;
               pend_freq = dp / dtm;
               valid_at  = c + W + 1;
               ready_at  = c + W + 2;
            end
         end
         m_primed = 1'b1;
         m_prev_p = p;
         m_prev_t = t;
      end
      @(posedge clk);
      #1;
      c++;
      if (r) begin
         m_primed = 1'b0;
         m_freq   = '0;
         valid_at = -1;
         ready_at = c;
      end
      reset    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic idle_until_ready();
      for (int k = 0; k < 100 && c < ready_at; k++) step(1'b0, 1'b0, '0, '0);
   endtask

   initial begin
      tbl[0] = '{1'b0, 27'd0,         27'd0,         1'b0, 27'd0,    1'b0};
      tbl[1] = '{1'b0, 27'd5000,      27'd5,         1'b1, 27'd1000, 1'b0};
      tbl[2] = '{1'b0, 27'd5000,      27'd5,         1'b1, 27'd1000, 1'b1};
      tbl[3] = '{1'b1, 27'h7FFFF00,   27'd100,       1'b0, 27'd0,    1'b0};
      tbl[4] = '{1'b0, 27'h0000100,   27'd102,       1'b1, 27'd256,  1'b0};
      tbl[5] = '{1'b1, 27'd0,         27'h7FFFFFE,   1'b0, 27'd0,    1'b0};
      tbl[6] = '{1'b0, 27'd4000,      27'h0000002,   1'b1, 27'd1000, 1'b0};
      tbl[7] = '{1'b0, 27'd4010,      27'h0000005,   1'b1, 27'd3,    1'b0};
      tbl[8] = '{1'b0, 27'd4010,      27'd9,         1'b1, 27'd0,    1'b0};

      reset    = 1'b1;
      in_valid = 1'b0;
      phase    = '0;
      tcnt     = '0;
      repeat (2) @(posedge clk);
      #1;
      c         = 0;
      ready_at  = 0;
      valid_at  = -1;
      m_primed  = 1'b0;
      m_freq    = '0;
      pend_freq = '0;
      pend_err  = 1'b0;
      m_prev_p  = '0;
      m_prev_t  = '0;
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_freq", 32'(freq), 32'd0);
      chk("rst_freq_valid", 32'(freq_valid), 32'd0);
      chk("rst_err_dt0", 32'(err_dt0), 32'd0);
      chk("rst_primed", 32'(primed), 32'd0);
      reset = 1'b0;

      // Directed vectors
      for (int i = 0; i < 9; i++) begin
         idle_until_ready();
         if (tbl[i].rst) step(1'b1, 1'b0, '0, '0);
         step(1'b0, 1'b1, tbl[i].ph, tbl[i].tc);
         if (tbl[i].out) begin
            for (int k = 0; k < 100 && c < valid_at; k++) step(1'b0, 1'b0, '0, '0);
            chk("tbl_freq_valid", 32'(freq_valid), 32'd1);
            chk("tbl_freq", 32'(freq), 32'(tbl[i].f));
            chk("tbl_err_dt0", 32'(err_dt0), 32'(tbl[i].e));
         end else begin
            chk("tbl_primed", 32'(primed), 32'd1);
         end
      end
      idle_until_ready();

      // Reset in the middle of a division
      step(1'b1, 1'b0, '0, '0);
      step(1'b0, 1'b1, 27'd0, 27'd0);
      step(1'b0, 1'b1, 27'd7000, 27'd7);
      repeat (9) step(1'b0, 1'b0, '0, '0);
      step(1'b1, 1'b0, '0, '0);
      chk("midrst_primed", 32'(primed), 32'd0);
      chk("midrst_freq", 32'(freq), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd1);
      repeat (30) step(1'b0, 1'b0, '0, '0);
      step(1'b0, 1'b1, 27'd123, 27'd77);
      repeat (40) step(1'b0, 1'b0, '0, '0);

      // Busy/ignore: in_valid held high with a new sample every cycle
      last_t = 27'd1000;
      for (int k = 0; k < 200; k++) begin
         last_t = last_t + 27'($urandom_range(0, 4));
         step(1'b0, 1'b1, 27'($urandom), last_t);
      end

      // Randomized traffic with realistic frequencies and occasional dt==0
      for (int k = 0; k < 1200; k++) begin
         logic [W-1:0] f, d;
         d = ($urandom_range(0, 7) == 0) ? 27'd0 : 27'($urandom_range(1, 2000));
         f = 27'($urandom_range(0, 60000));
         if ($urandom_range(0, 9) == 0) f = 27'($urandom);
         step(1'b0, 1'($urandom_range(0, 1)), m_prev_p + f * d, m_prev_t + d);
      end
      idle_until_ready();
      step(1'b0, 1'b0, '0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/phtime_freq_est.md
Name: phtime_freq_est

Overview:
- Inverse of the phase-time product block: recovers the 27-bit frequency word from two successive (phase, time-count) samples.
- The phase-time block computes phase = freq*tcnt mod 2^27. This block computes freq = floor(dphase/dt), where dphase and dt are modular deltas between consecutive accepted samples.
- Used to check and calibrate per-channel DDS frequency words from captured phase timestamps.
- Uses a bit-serial restoring divider, so no DSP slice is needed.

Parameters:
- WIDTH, 27: width of phase, tcnt and freq words.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- phase  input  WIDTH  sampled phase word
- tcnt  input  WIDTH  time count at which phase was sampled
- in_valid  input  1  sample present
- in_ready  output  1  block can accept a sample this cycle
- freq  output  WIDTH  recovered frequency word; holds its value between results
- freq_valid  output  1  one-cycle pulse: freq/err_dt0 updated
- err_dt0  output  1  valid with freq_valid: delta-time was zero
- primed  output  1  a reference sample is held

Behaviour:
- Reset values: in_ready=1, freq=0, freq_valid=0, err_dt0=0, primed=0, FSM=IDLE.
- Reset mid-operation aborts any division: no freq_valid pulse, stored reference discarded.
- Accept condition: in_valid && in_ready, at cycle A. in_ready=1 only in state IDLE.
- in_valid while busy is ignored. Nothing is queued; the sample is lost.
- Every accepted sample updates the stored prev_phase and prev_tcnt.
- First accepted sample with primed=0:
  - stored only; primed=1 from A+1.
  - no output; FSM stays IDLE.
- Accepted sample with primed=1:
  - at edge A, register dphase=(phase-prev_phase) mod 2^WIDTH and dt=(tcnt-prev_tcnt) mod 2^WIDTH.
  - modular subtraction, so wrap of either counter is handled.
- FSM states:
  - IDLE -> DIV when primed=1, sample accepted and dt!=0.
  - IDLE -> DONE when dt==0.
  - DIV: WIDTH iterations, one quotient bit per cycle, MSB first, cycles A+1..A+WIDTH.
  - DONE: one cycle, then -> IDLE.
- Divider arithmetic:
  - remainder register WIDTH+1 bits.
  - each step: shift in the next dividend bit; subtract dt if remainder>=dt and set the quotient bit.
  - quotient = floor(dphase/dt); the remainder is discarded.
- Normal timing (dt!=0):
  - DONE at cycle A+WIDTH+1 (A+28 for the default): freq=quotient, freq_valid=1, err_dt0=0.
  - in_ready=1 again at A+WIDTH+2.
- dt==0:
  - DONE at A+1 with freq_valid=1, err_dt0=1, freq unchanged.
  - in_ready=1 again at A+2.
- Exactness: the result equals the true freq when freq*dt < 2^WIDTH, i.e. the phase did not wrap more than once over the interval. Otherwise the result is floor of the wrapped delta; this limitation is documented, not flagged.
- dphase=0 with dt!=0 gives freq=0 through the normal path.
- Throughput: one result per WIDTH+2 cycles maximum.

Test Plan:
- Default WIDTH unless stated.
- Basic: reset; accept (phase=0, tcnt=0), then at cycle A accept (phase=5000, tcnt=5) -> freq_valid exactly at A+28 with freq=1000, err_dt0=0; in_ready=0 during A+1..A+28, 1 at A+29.
- Phase wrap: prev (phase=0x7FFFF00, tcnt=100), next (phase=0x0000100, tcnt=102) -> dphase=512, dt=2, freq=256.
- Tcnt wrap and inexact division:
  - prev (phase=0, tcnt=0x7FFFFFE), next (phase=4000, tcnt=0x0000002) -> freq=1000.
  - then next (phase=4010, tcnt=0x0000005) -> dphase=10, dt=3, freq=3.
- dt==0: after a result of freq=1000, accept a sample with tcnt equal to prev tcnt -> freq_valid and err_dt0 at A+1, freq stays 1000, in_ready=1 at A+2.
- Busy/ignore: hold in_valid=1 with changing samples throughout a division -> only samples taken while in_ready=1 are accepted; results match the accepted pairs only.
- Reset mid-division: assert reset at A+10 for one cycle -> no freq_valid ever; primed=0, freq=0, in_ready=1 after reset; next sample only re-primes and produces no output.
